fifo_wptr_full: RTL

// - Write-side pointer and full-flag generator of the async FIFO; source end of the gray-pointer crossing.
// - Keeps the write binary counter and drives the RAM write address.
// - Publishes a registered gray write pointer that the read domain captures through its 2-FF synchroniser.
// - Compares the synchronised gray read pointer against the next write pointer to produce a registered full flag.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/gray_to_bin.sv | 14 +
 rtl/fifo_wptr_full.sv | 85 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: gray/binary conversion and
// the full-compare used by both the write-side full and read-side empty generators.
package fifo_pkg;

   localparam int unsigned ASIZE_DEFAULT = 4;
   localparam int unsigned DEPTH         = 1 << ASIZE_DEFAULT;

   // Helpers work on a 32-bit carrier; callers zero-extend and truncate to ASIZE+1.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin = gray;
      for (int s = 1; s < 32; s = s * 2) begin
         bin = bin ^ (bin >> s);
      end
      return bin;
   endfunction

   // Full when the write pointer has lapped the read pointer exactly once:
   // top two gray bits inverted, the rest equal.
   function automatic logic ptr_full(input logic [31:0] wgray,
                                     input logic [31:0] rgray,
                                     input int unsigned asize);
      return wgray == (rgray ^ (32'd3 << (asize - 1)));
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all
// gray bits at or above it.
module gray_to_bin #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[W-1:i];
   end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and registered full flag of the async FIFO (gray-pointer source).
// Optional registered almost-full output enabled by macro FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int ASIZE          = 4,
   parameter int ALMOST_FULL_TH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             winc,
   input  logic [ASIZE:0]   wq2_rptr,
   output logic [ASIZE-1:0] waddr,
   output logic [ASIZE:0]   wptr,
   output logic             wfull,
`ifdef FIFO_ALMOST_FULL_EN
   output logic             walmost_full,
`endif
   output logic             wovf
);

   localparam int PW = ASIZE + 1;

   logic [ASIZE:0] wbin_q, wbin_d;
   logic [ASIZE:0] wptr_q, wptr_d;
   logic           wfull_q, wfull_d;
   logic           wovf_q, wovf_d;
   logic           wen;

   // Full is evaluated against the pointer this edge will publish, so the
   // write that fills the last slot raises wfull on its own edge.
   always_comb begin
      wen     = winc & ~wfull_q;
      wbin_d  = wbin_q + PW'(wen);
      wptr_d  = PW'(bin2gray(32'(wbin_d)));
      wfull_d = ptr_full(32'(wptr_d), 32'(wq2_rptr), ASIZE);
      wovf_d  = wovf_q | (winc & wfull_q);
   end

`ifdef FIFO_ALMOST_FULL_EN
   localparam int unsigned FIFO_DEPTH = 1 << ASIZE;

   logic [ASIZE:0] rbin;
   logic [ASIZE:0] occ;
   logic           walmost_full_q, walmost_full_d;

   gray_to_bin #(.W(PW)) u_rptr_g2b (
      .gray_i (wq2_rptr),
      .bin_o  (rbin)
   );

   assign occ            = wbin_d - rbin;
   assign walmost_full_d = (occ >= PW'(FIFO_DEPTH - ALMOST_FULL_TH));
   assign walmost_full   = walmost_full_q;
`else
   logic unused_th;
   assign unused_th = ALMOST_FULL_TH[0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q         <= '0;
         wptr_q         <= '0;
         wfull_q        <= 1'b0;
         wovf_q         <= 1'b0;
`ifdef FIFO_ALMOST_FULL_EN
         walmost_full_q <= 1'b0;
`endif
      end else begin
         wbin_q         <= wbin_d;
         wptr_q         <= wptr_d;
         wfull_q        <= wfull_d;
         wovf_q         <= wovf_d;
`ifdef FIFO_ALMOST_FULL_EN
         walmost_full_q <= walmost_full_d;
`endif
      end
   end

   assign waddr = wbin_q[ASIZE-1:0];
   assign wptr  = wptr_q;
   assign wfull = wfull_q;
   assign wovf  = wovf_q;

endmodule
